multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle control sequencer for the 16-bit processor datapath.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, so instruction and data memory can take variable latency through ready handshakes.
- Drives the same control strobes the datapath already consumes (reg_dst, mem_to_reg, alu_op, jump, beq, bne, mem_read, mem_write, alu_src, reg_write), plus ir_write and pc_write.
- Sits between the datapath (which supplies opcode) and the instruction/data memories.

Parameters:
- OPCODE_W, 4, opcode width; fixed by the ISA.
- MEM_TIMEOUT, 15, maximum wait cycles for imem_ready/dmem_ready before fault; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level enable; sampled in IDLE and at instruction boundaries.
- opcode  in  OPCODE_W  instruction opcode from the IR; valid from DECODE onward.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC+2.
- reg_dst, mem_to_reg, jump, beq, bne, mem_read, mem_write, alu_src, reg_write  out  1 each  datapath controls.
- alu_op  out  2  00 add, 01 sub (compare), 10 R-type (funct-decoded).
- busy  out  1  high in any state except IDLE and FAULT.
- fault  out  1  sticky error flag.
- retired_cnt  out  32  instructions retired.
- stall_cnt  out  32  memory wait cycles.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, op_q=0, wait counter=0, fault=0, counters=0.
  - All outputs 0 immediately, including when reset hits mid-instruction.
- Opcode classes (anything not listed is illegal):
  - 0000 LW; 0001 SW; 0010–1001 R-type.
  - 1011 BEQ; 1100 BNE; 1101 JMP.
  - 1010, 1110, 1111 illegal.
- IDLE: run=1 -> FETCH.
- FETCH:
  - imem_req=1.
  - On imem_ready=1 in the same cycle: ir_write=1 and pc_write=1 (Mealy), then -> DECODE.
- DECODE:
  - Latch opcode into op_q.
  - Illegal opcode -> FAULT; otherwise -> EXEC.
  - No datapath strobes asserted.
- EXEC (controls decoded from op_q):
  - LW/SW: alu_src=1, alu_op=00, then -> MEM.
  - R-type: alu_op=10, then -> WB.
  - BEQ/BNE: alu_op=01, one-cycle beq/bne pulse, then -> boundary.
  - JMP: one-cycle jump pulse, then -> boundary.
- MEM:
  - mem_read (LW) or mem_write (SW) held high until dmem_ready=1.
  - LW -> WB; SW -> boundary.
- WB:
  - reg_write=1 for one cycle.
  - LW: mem_to_reg=1. R-type: reg_dst=1.
  - Then -> boundary.
- Boundary: retired_cnt += 1; run=1 -> FETCH, else -> IDLE.
- Latency with zero-wait memory (counting FETCH as the cycle where ready=1):
  - JMP/BEQ/BNE: 3 cycles.
  - SW and R-type: 4 cycles.
  - LW: 5 cycles.
  - Each wait cycle adds 1.
- Wait counter:
  - Increments each FETCH/MEM cycle while the relevant ready=0.
  - Clears on ready.
  - Reaching MEM_TIMEOUT -> FAULT.
  - Each wait cycle increments stall_cnt.
- FAULT:
  - All strobes 0, fault=1, busy=0.
  - Exit only via reset; run is ignored.
- run deasserted mid-instruction: the instruction completes; run is checked only at the boundary.
- Ready asserted when not requested: ignored.
- Counters wrap modulo 2^32.

Optional Feature:
- Macro: MULTICYCLE_PERF_EN.
- Defined: retired_cnt and stall_cnt count as described.
- Undefined: both ports tied to 0; no counter flops are synthesised.

Decomposition:
- Shared package (e.g. riscv16_pkg) holds:
  - state enum: IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT.
  - opcode constants: OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JMP, R-type range bounds.
  - alu_op constants: ALU_ADD, ALU_SUB, ALU_RTYPE.
- One natural sub-module, multicycle_wait_timer: the wait counter plus timeout compare, reused for imem and dmem waits.

Test Plan:
- Reset then run=1, imem_ready=1 always, opcode=0010 -> ir_write at cycle 1, reg_write+reg_dst at cycle 4, retired_cnt=1.
- LW with dmem_ready delayed 3 cycles -> mem_read held 4 cycles, then mem_to_reg+reg_write, stall_cnt=3, total 8 cycles.
- BEQ (1011) then JMP (1101) back-to-back -> beq pulse at cycle 3, jump pulse at cycle 6, no reg_write asserted.
- opcode=1110 -> FAULT at cycle 3, fault=1, all strobes 0, stays until rst_n=0.
- imem_ready held 0 with MEM_TIMEOUT=15 -> fault=1 after 15 wait cycles, imem_req drops.
- rst_n pulsed low during MEM of SW -> mem_write=0 asynchronously, state IDLE, fault=0; with run=0 at boundary -> IDLE, busy=0.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// Shared types and ISA constants for the multi-cycle control sequencer.
package multicycle_sequencer_pkg;

    localparam int ISA_OPCODE_W = 4;

    typedef logic [ISA_OPCODE_W-1:0] opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_FAULT
    } state_t;

    localparam opcode_t OP_LW       = 4'b0000;
    localparam opcode_t OP_SW       = 4'b0001;
    localparam opcode_t OP_RTYPE_LO = 4'b0010;
    localparam opcode_t OP_RTYPE_HI = 4'b1001;
    localparam opcode_t OP_BEQ      = 4'b1011;
    localparam opcode_t OP_BNE      = 4'b1100;
    localparam opcode_t OP_JMP      = 4'b1101;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;

    function automatic logic is_rtype(input opcode_t op);
        return (op >= OP_RTYPE_LO) && (op <= OP_RTYPE_HI);
    endfunction

    function automatic logic is_legal(input opcode_t op);
        return (op == OP_LW) || (op == OP_SW) || is_rtype(op) ||
               (op == OP_BEQ) || (op == OP_BNE) || (op == OP_JMP);
    endfunction

endpackage

// File: rtl/multicycle_wait_timer.sv
// Memory wait counter with timeout compare; shared by instruction and data waits.
module multicycle_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    output logic timeout
);

    logic [7:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (waiting) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Fires on the MEM_TIMEOUT-th consecutive wait cycle, so the count never exceeds 254.
    assign timeout = waiting && (wait_cnt == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB control sequencer for the 16-bit datapath.
// Define MULTICYCLE_PERF_EN to build the retired/stall performance counters.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int OPCODE_W    = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                ir_write,
    output logic                pc_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic [1:0]          alu_op,
    output logic                jump,
    output logic                beq,
    output logic                bne,
    output logic                mem_read,
    output logic                mem_write,
    output logic                alu_src,
    output logic                reg_write,
    output logic                busy,
    output logic                fault,
    output logic [31:0]         retired_cnt,
    output logic [31:0]         stall_cnt
);

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q;
    logic                retire;
    logic                waiting;
    logic                timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    assign waiting = ((state_q == ST_FETCH) && !imem_ready) ||
                     ((state_q == ST_MEM)   && !dmem_ready);

    multicycle_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .waiting(waiting),
        .timeout(timeout)
    );

    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = ALU_ADD;
        jump       = 1'b0;
        beq        = 1'b0;
        bne        = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DECODE: begin
                state_d = is_legal(opcode) ? ST_EXEC : ST_FAULT;
            end
            ST_EXEC: begin
                if ((op_q == OP_LW) || (op_q == OP_SW)) begin
                    alu_src = 1'b1;
                    alu_op  = ALU_ADD;
                    state_d = ST_MEM;
                end else if (is_rtype(op_q)) begin
                    alu_op  = ALU_RTYPE;
                    state_d = ST_WB;
                end else if ((op_q == OP_BEQ) || (op_q == OP_BNE)) begin
                    alu_op = ALU_SUB;
                    beq    = (op_q == OP_BEQ);
                    bne    = (op_q == OP_BNE);
                    retire = 1'b1;
                end else if (op_q == OP_JMP) begin
                    jump   = 1'b1;
                    retire = 1'b1;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            ST_MEM: begin
                mem_read  = (op_q == OP_LW);
                mem_write = (op_q == OP_SW);
                if (dmem_ready) begin
                    if (op_q == OP_LW) state_d = ST_WB;
                    else               retire  = 1'b1;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_q == OP_LW);
                reg_dst    = is_rtype(op_q);
                retire     = 1'b1;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Instruction boundary: run is only honoured here and in IDLE.
        if (retire) state_d = run ? ST_FETCH : ST_IDLE;
    end

    assign busy  = (state_q != ST_IDLE) && (state_q != ST_FAULT);
    assign fault = (state_q == ST_FAULT);

`ifdef MULTICYCLE_PERF_EN
    logic [31:0] retired_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (retire)  retired_q <= retired_q + 32'd1;
            if (waiting) stall_q   <= stall_q + 32'd1;
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`else
    logic perf_unused;
    assign perf_unused = retire;
    assign retired_cnt = '0;
    assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized self-checking bench for multicycle_sequencer with a cycle-schedule reference model.
module tb_multicycle_sequencer;

    localparam int OPCODE_W    = 4;
    localparam int MEM_TIMEOUT = 15;

    localparam logic [15:0] E_IMEM = 16'h8000, E_IRW = 16'h4000, E_PCW = 16'h2000;
    localparam logic [15:0] E_RDST = 16'h1000, E_M2R = 16'h0800, E_JMP = 16'h0400;
    localparam logic [15:0] E_BEQ  = 16'h0200, E_BNE = 16'h0100, E_MRD = 16'h0080;
    localparam logic [15:0] E_MWR  = 16'h0040, E_ASRC = 16'h0020, E_RWR = 16'h0010;
    localparam logic [15:0] E_ALU_R = 16'h0008, E_ALU_SUB = 16'h0004;
    localparam logic [15:0] E_BUSY = 16'h0002, E_FAULT = 16'h0001;

    logic clk = 1'b0;
    logic rst_n, run, imem_ready, dmem_ready;
    logic [OPCODE_W-1:0] opcode;
    logic imem_req, ir_write, pc_write, reg_dst, mem_to_reg, jump, beq, bne;
    logic mem_read, mem_write, alu_src, reg_write, busy, fault;
    logic [1:0]  alu_op;
    logic [31:0] retired_cnt, stall_cnt;
    logic [15:0] outv;

    multicycle_sequencer #(.OPCODE_W(OPCODE_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
        .jump(jump), .beq(beq), .bne(bne), .mem_read(mem_read),
        .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write),
        .busy(busy), .fault(fault), .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    assign outv = {imem_req, ir_write, pc_write, reg_dst, mem_to_reg, jump, beq, bne,
                   mem_read, mem_write, alu_src, reg_write, alu_op, busy, fault};

    typedef struct {
        logic        run;
        logic        ird;
        logic        drd;
        logic [3:0]  opc;
        logic [15:0] exp;
    } cyc_t;

    cyc_t sched[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_retired;
    int   exp_stall;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] want_retired();
`ifdef MULTICYCLE_PERF_EN
        return 32'(exp_retired);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] want_stall();
`ifdef MULTICYCLE_PERF_EN
        return 32'(exp_stall);
`else
        return 32'd0;
`endif
    endfunction

    task automatic push(input logic r, input logic ir, input logic dr,
                        input logic [3:0] op, input logic [15:0] e);
        cyc_t c;
        c.run = r; c.ird = ir; c.drd = dr; c.opc = op; c.exp = e;
        sched.push_back(c);
    endtask

    // Expands one instruction into its per-cycle expected strobes. The final
    // cycle of an instruction is its boundary, where run decides what follows.
    task automatic add_instr(input logic [3:0] op, input int wi, input int wd, input bit last);
        int          o;
        logic        fin;
        logic [15:0] mem;
        o   = int'(op);
        fin = !last;
        for (int k = 0; k < wi; k++) begin
            push(rb(), 1'b0, rb(), 4'($urandom), E_IMEM | E_BUSY);
            exp_stall++;
        end
        push(rb(), 1'b1, rb(), 4'($urandom), E_IMEM | E_IRW | E_PCW | E_BUSY);
        push(rb(), rb(), rb(), op, E_BUSY);
        if (o <= 1) begin
            mem = (o == 0) ? E_MRD : E_MWR;
            push(rb(), rb(), rb(), op, E_BUSY | E_ASRC);
            for (int k = 0; k < wd; k++) begin
                push(rb(), rb(), 1'b0, op, E_BUSY | mem);
                exp_stall++;
            end
            push((o == 1) ? fin : rb(), rb(), 1'b1, op, E_BUSY | mem);
            if (o == 0) push(fin, rb(), rb(), op, E_BUSY | E_RWR | E_M2R);
        end else if (o <= 9) begin
            push(rb(), rb(), rb(), op, E_BUSY | E_ALU_R);
            push(fin, rb(), rb(), op, E_BUSY | E_RWR | E_RDST);
        end else if (o == 11) begin
            push(fin, rb(), rb(), op, E_BUSY | E_ALU_SUB | E_BEQ);
        end else if (o == 12) begin
            push(fin, rb(), rb(), op, E_BUSY | E_ALU_SUB | E_BNE);
        end else begin
            push(fin, rb(), rb(), op, E_BUSY | E_JMP);
        end
        exp_retired++;
    endtask

    task automatic step(input cyc_t c, output logic [15:0] obs);
        @(negedge clk);
        run = c.run; imem_ready = c.ird; dmem_ready = c.drd; opcode = c.opc;
        #2;
        obs = outv;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sched.delete();
        exp_retired = 0;
        exp_stall   = 0;
    endtask

    task automatic test_reset();
        #1;
        run = rb(); imem_ready = rb(); dmem_ready = rb(); opcode = 4'($urandom);
        #1;
        n_checks++;
        if (outv !== 16'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h, expected %h", outv, 16'h0);
        end
        n_checks++;
        if (retired_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_retired: got %0d, expected 0", retired_cnt);
        end
        n_checks++;
        if (stall_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_stall: got %0d, expected 0", stall_cnt);
        end
        do_reset();
    endtask

    task automatic test_rtype();
        logic [15:0] obs;
        do_reset();
        push(1'b1, rb(), rb(), 4'($urandom), 16'h0);
        add_instr(4'b0010, 0, 0, 1'b1);
        push(1'b0, rb(), rb(), 4'($urandom), 16'h0);
        for (int i = 0; i < sched.size(); i++) begin
            step(sched[i], obs);
            n_checks++;
            if (obs !== sched[i].exp) begin
                n_fail++; $display("FAIL rtype cycle %0d: got %h, expected %h", i, obs, sched[i].exp);
            end
        end
        n_checks++;
        if (retired_cnt !== want_retired()) begin
            n_fail++; $display("FAIL rtype_retired: got %0d, expected %0d", retired_cnt, want_retired());
        end
    endtask

    task automatic test_lw_wait();
        logic [15:0] obs;
        do_reset();
        push(1'b1, rb(), rb(), 4'($urandom), 16'h0);
        add_instr(4'b0000, 0, 3, 1'b0);
        add_instr(4'b0001, MEM_TIMEOUT - 1, MEM_TIMEOUT - 1, 1'b1);
        push(1'b0, rb(), rb(), 4'($urandom), 16'h0);
        for (int i = 0; i < sched.size(); i++) begin
            step(sched[i], obs);
            n_checks++;
            if (obs !== sched[i].exp) begin
                n_fail++; $display("FAIL lw_wait cycle %0d: got %h, expected %h", i, obs, sched[i].exp);
            end
        end
        n_checks++;
        if (stall_cnt !== want_stall()) begin
            n_fail++; $display("FAIL lw_wait_stall: got %0d, expected %0d", stall_cnt, want_stall());
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] obs;
        do_reset();
        push(1'b1, rb(), rb(), 4'($urandom), 16'h0);
        add_instr(4'b1011, 0, 0, 1'b0);
        add_instr(4'b1101, 0, 0, 1'b0);
        add_instr(4'b1100, 1, 0, 1'b1);
        push(1'b0, rb(), rb(), 4'($urandom), 16'h0);
        for (int i = 0; i < sched.size(); i++) begin
            step(sched[i], obs);
            n_checks++;
            if (obs !== sched[i].exp) begin
                n_fail++; $display("FAIL back_to_back cycle %0d: got %h, expected %h", i, obs, sched[i].exp);
            end
        end
        n_checks++;
        if (retired_cnt !== want_retired()) begin
            n_fail++; $display("FAIL back_to_back_retired: got %0d, expected %0d", retired_cnt, want_retired());
        end
    endtask

    task automatic test_random();
        logic [15:0] obs;
        int o, wi, wd;
        do_reset();
        push(1'b1, rb(), rb(), 4'($urandom), 16'h0);
        for (int n = 0; n < 25; n++) begin
            o = int'($urandom_range(0, 12));
            if (o >= 10) o = o + 1;
            wi = ($urandom_range(0, 7) == 0) ? MEM_TIMEOUT - 1 : int'($urandom_range(0, 3));
            wd = ($urandom_range(0, 7) == 0) ? MEM_TIMEOUT - 1 : int'($urandom_range(0, 3));
            add_instr(4'(o), wi, wd, n == 24);
        end
        push(1'b0, rb(), rb(), 4'($urandom), 16'h0);
        for (int i = 0; i < sched.size(); i++) begin
            step(sched[i], obs);
            n_checks++;
            if (obs !== sched[i].exp) begin
                n_fail++; $display("FAIL random cycle %0d: got %h, expected %h", i, obs, sched[i].exp);
            end
        end
        n_checks++;
        if (retired_cnt !== want_retired()) begin
            n_fail++; $display("FAIL random_retired: got %0d, expected %0d", retired_cnt, want_retired());
        end
        n_checks++;
        if (stall_cnt !== want_stall()) begin
            n_fail++; $display("FAIL random_stall: got %0d, expected %0d", stall_cnt, want_stall());
        end
    endtask

    task automatic test_illegal();
        logic [15:0] obs;
        logic [3:0]  bad;
        case ($urandom_range(0, 2))
            0:       bad = 4'b1010;
            1:       bad = 4'b1110;
            default: bad = 4'b1111;
        endcase
        do_reset();
        push(1'b1, rb(), rb(), 4'($urandom), 16'h0);
        push(rb(), 1'b1, rb(), 4'($urandom), E_IMEM | E_IRW | E_PCW | E_BUSY);
        push(rb(), rb(), rb(), bad, E_BUSY);
        for (int k = 0; k < 8; k++) push(rb(), rb(), rb(), 4'($urandom), E_FAULT);
        for (int i = 0; i < sched.size(); i++) begin
            step(sched[i], obs);
            n_checks++;
            if (obs !== sched[i].exp) begin
                n_fail++; $display("FAIL illegal cycle %0d: got %h, expected %h", i, obs, sched[i].exp);
            end
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (outv !== 16'h0) begin
            n_fail++; $display("FAIL illegal_reset_clears: got %h, expected %h", outv, 16'h0);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] obs;
        do_reset();
        push(1'b1, rb(), rb(), 4'($urandom), 16'h0);
        for (int k = 0; k < MEM_TIMEOUT; k++) begin
            push(rb(), 1'b0, rb(), 4'($urandom), E_IMEM | E_BUSY);
            exp_stall++;
        end
        for (int k = 0; k < 5; k++) push(rb(), rb(), rb(), 4'($urandom), E_FAULT);
        for (int i = 0; i < sched.size(); i++) begin
            step(sched[i], obs);
            n_checks++;
            if (obs !== sched[i].exp) begin
                n_fail++; $display("FAIL imem_timeout cycle %0d: got %h, expected %h", i, obs, sched[i].exp);
            end
        end
        n_checks++;
        if (stall_cnt !== want_stall()) begin
            n_fail++; $display("FAIL imem_timeout_stall: got %0d, expected %0d", stall_cnt, want_stall());
        end
        do_reset();
        push(1'b1, rb(), rb(), 4'($urandom), 16'h0);
        push(rb(), 1'b1, rb(), 4'($urandom), E_IMEM | E_IRW | E_PCW | E_BUSY);
        push(rb(), rb(), rb(), 4'b0000, E_BUSY);
        push(rb(), rb(), rb(), 4'b0000, E_BUSY | E_ASRC);
        for (int k = 0; k < MEM_TIMEOUT; k++) begin
            push(rb(), rb(), 1'b0, 4'b0000, E_BUSY | E_MRD);
            exp_stall++;
        end
        for (int k = 0; k < 5; k++) push(rb(), rb(), rb(), 4'($urandom), E_FAULT);
        for (int i = 0; i < sched.size(); i++) begin
            step(sched[i], obs);
            n_checks++;
            if (obs !== sched[i].exp) begin
                n_fail++; $display("FAIL dmem_timeout cycle %0d: got %h, expected %h", i, obs, sched[i].exp);
            end
        end
        n_checks++;
        if (stall_cnt !== want_stall()) begin
            n_fail++; $display("FAIL dmem_timeout_stall: got %0d, expected %0d", stall_cnt, want_stall());
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [15:0] obs;
        cyc_t        idle;
        do_reset();
        push(1'b1, rb(), rb(), 4'($urandom), 16'h0);
        add_instr(4'b0001, 0, 6, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(sched[i], obs);
            n_checks++;
            if (obs !== sched[i].exp) begin
                n_fail++; $display("FAIL reset_mid_mem cycle %0d: got %h, expected %h", i, obs, sched[i].exp);
            end
        end
        #1 rst_n = 1'b0;
        run = 1'b0;
        #1;
        n_checks++;
        if (outv !== 16'h0) begin
            n_fail++; $display("FAIL reset_mid_mem_async: got %h, expected %h", outv, 16'h0);
        end
        n_checks++;
        if ({retired_cnt, stall_cnt} !== 64'd0) begin
            n_fail++; $display("FAIL reset_mid_mem_counters: got %0d/%0d, expected 0/0", retired_cnt, stall_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle.run = 1'b0; idle.ird = rb(); idle.drd = rb(); idle.opc = 4'($urandom); idle.exp = 16'h0;
            step(idle, obs);
            n_checks++;
            if (obs !== idle.exp) begin
                n_fail++; $display("FAIL reset_mid_mem_idle cycle %0d: got %h, expected %h", i, obs, idle.exp);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; opcode = '0;
        exp_retired = 0; exp_stall = 0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_back_to_back();
        test_random();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
